// File: rtl/rx_history_display_pkg.sv
// Shared constants for the received-value history display.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package rx_history_display_pkg;

    localparam int HIST_DEPTH = 4;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_0 = 4'b1110;
    localparam logic [3:0] AN_1 = 4'b1101;
    localparam logic [3:0] AN_2 = 4'b1011;
    localparam logic [3:0] AN_3 = 4'b0111;

    function automatic logic [3:0] an_pattern(input logic [1:0] sel);
        logic [3:0] an;
        an = AN_0;
        unique case (1'b1)
            (sel == 2'd0): an = AN_0;
            (sel == 2'd1): an = AN_1;
            (sel == 2'd2): an = AN_2;
            (sel == 2'd3): an = AN_3;
        endcase
        return an;
    endfunction

endpackage

// File: rtl/rx_history_display_if.sv
// Link-side bundle: received value, its valid level and the clear pulse.
// master drives the link, slave is the history display.
interface rx_history_display_if;
    logic       data_valid;
    logic [2:0] data_in;
    logic       clear;

    modport master (output data_valid, output data_in, output clear);
    modport slave  (input  data_valid, input  data_in, input  clear);
endinterface

// File: rtl/rx_history_display_seg_decode_3b.sv
// 3-bit value plus occupied flag to active-low seven-segment pattern.
// Unoccupied digits are blanked.
module seg_decode_3b
    import rx_history_display_pkg::*;
(
    input  logic [2:0] value,
    input  logic       occupied,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (occupied) begin
            unique case (value)
                3'd0: seg = SEG_0;
                3'd1: seg = SEG_1;
                3'd2: seg = SEG_2;
                3'd3: seg = SEG_3;
                3'd4: seg = SEG_4;
                3'd5: seg = SEG_5;
                3'd6: seg = SEG_6;
                3'd7: seg = SEG_7;
            endcase
        end
    end

endmodule

// File: rtl/rx_history_display.sv
// Four-deep history of received 3-bit values shown on a multiplexed
// seven-segment display, newest value on the rightmost digit.
module rx_history_display
    import rx_history_display_pkg::*;
#(
    parameter int REFRESH_BITS = 17
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rx_history_display_if.slave   link,
    output logic [6:0]            seven_seg,
    output logic [3:0]            AN,
    output logic [3:0]            rx_count
);

    logic                    dv_q;
    logic                    capture;
    logic [2:0]              entry [HIST_DEPTH];
    logic [HIST_DEPTH-1:0]   occ;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [1:0]              sel;
    logic [2:0]              cur_val;
    logic                    cur_occ;
    logic [6:0]              seg_next;

    assign capture = link.data_valid & ~dv_q;

    // Clear wins over a simultaneous capture; the captured value is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_q     <= 1'b0;
            occ      <= '0;
            rx_count <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) entry[i] <= '0;
        end else begin
            dv_q <= link.data_valid;
            if (link.clear) begin
                occ      <= '0;
                rx_count <= '0;
                for (int i = 0; i < HIST_DEPTH; i++) entry[i] <= '0;
            end else if (capture) begin
                for (int i = HIST_DEPTH - 1; i > 0; i--) entry[i] <= entry[i-1];
                entry[0] <= link.data_in;
                occ      <= {occ[HIST_DEPTH-2:0], 1'b1};
                rx_count <= rx_count + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) refresh_cnt <= '0;
        else        refresh_cnt <= refresh_cnt + 1'b1;
    end

    assign sel     = refresh_cnt[REFRESH_BITS-1 -: 2];
    assign cur_val = entry[sel];
    assign cur_occ = occ[sel];

    seg_decode_3b u_dec (
        .value    (cur_val),
        .occupied (cur_occ),
        .seg      (seg_next)
    );

    // AN and segments share one register stage so digits never ghost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            AN        <= AN_0;
            seven_seg <= SEG_BLANK;
        end else begin
            AN        <= an_pattern(sel);
            seven_seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_rx_history_display.sv
// Directed self-checking bench for rx_history_display.
// REFRESH_BITS=4; inputs driven and outputs sampled on negedges.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s: obs %0b exp %0b", tag, obs, exp); \
    end \
  end

module tb_rx_history_display;

  logic       clk;
  logic       rst_n;
  logic [6:0] seven_seg;
  logic [3:0] AN;
  logic [3:0] rx_count;
  int         errors;
  int         checks;

  logic [3:0] an_tab  [4];
  logic [6:0] seg_tab [8];
  localparam logic [6:0] BLANK = 7'b1111111;

  rx_history_display_if link ();

  rx_history_display #(.REFRESH_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .link      (link),
    .seven_seg (seven_seg),
    .AN        (AN),
    .rx_count  (rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_slot(
    input int         idx,
    input logic [6:0] exp,
    input string      tag
  );
    int n;
    n = 0;
    while (AN !== an_tab[idx] && n < 24) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 24) begin
      errors++;
      $error("FAIL %s: wait for AN expired", tag);
    end
    `CHK($sformatf("%s_an", tag), AN, an_tab[idx])
    `CHK(tag, seven_seg, exp)
  endtask

  task automatic capture(input logic [2:0] v);
    @(negedge clk);
    link.data_in    = v;
    link.data_valid = 1'b1;
    @(negedge clk);
    link.data_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    link.clear = 1'b1;
    @(negedge clk);
    link.clear = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;
    an_tab[0] = 4'b1110; an_tab[1] = 4'b1101;
    an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
    seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
    seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;

    rst_n           = 1'b0;
    link.data_valid = 1'b0;
    link.data_in    = 3'd0;
    link.clear      = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (AN !== 4'b1110 || seven_seg !== BLANK ||
        rx_count !== 4'd0) begin
      errors++;
      $error("FAIL rst_state: AN %b seg %b cnt %0d",
             AN, seven_seg, rx_count);
    end
    `CHK("rst_an", AN, 4'b1110)
    `CHK("rst_seg", seven_seg, BLANK)
    `CHK("rst_cnt", rx_count, 4'd0)
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      `CHK($sformatf("scan_an%0d", i), AN, an_tab[i/4])
      `CHK($sformatf("scan_seg%0d", i), seven_seg, BLANK)
      `CHK($sformatf("scan_cnt%0d", i), rx_count, 4'd0)
    end

    link.data_in    = 3'd3;
    link.data_valid = 1'b1;
    repeat (3) @(negedge clk);
    link.data_in = 3'd5;
    repeat (7) @(negedge clk);
    link.data_valid = 1'b0;
    @(negedge clk);
    `CHK("hold_cnt", rx_count, 4'd1)
    check_slot(0, seg_tab[3], "hold_d0");
    check_slot(1, BLANK, "hold_d1");
    check_slot(2, BLANK, "hold_d2");
    check_slot(3, BLANK, "hold_d3");

    pulse_clear();
    `CHK("clr_cnt", rx_count, 4'd0)
    capture(3'd1);
    capture(3'd2);
    capture(3'd5);
    capture(3'd7);
    capture(3'd4);
    `CHK("seq_cnt", rx_count, 4'd5)
    check_slot(0, seg_tab[4], "seq_d0");
    check_slot(1, seg_tab[7], "seq_d1");
    check_slot(2, seg_tab[5], "seq_d2");
    check_slot(3, seg_tab[2], "seq_d3");

    @(negedge clk);
    link.clear      = 1'b1;
    link.data_valid = 1'b1;
    link.data_in    = 3'd6;
    @(negedge clk);
    link.clear      = 1'b0;
    link.data_valid = 1'b0;
    @(negedge clk);
    `CHK("cc_cnt", rx_count, 4'd0)
    for (int i = 0; i < 4; i++)
      check_slot(i, BLANK, $sformatf("cc_d%0d", i));
    capture(3'd0);
    `CHK("cc0_cnt", rx_count, 4'd1)
    check_slot(0, seg_tab[0], "cc0_d0");
    check_slot(1, BLANK, "cc0_d1");
    check_slot(2, BLANK, "cc0_d2");
    check_slot(3, BLANK, "cc0_d3");

    pulse_clear();
    for (int i = 0; i < 17; i++) capture(3'(i % 8));
    `CHK("wrap_cnt", rx_count, 4'd1)
    check_slot(0, seg_tab[0], "wrap_d0");
    check_slot(1, seg_tab[7], "wrap_d1");
    check_slot(2, seg_tab[6], "wrap_d2");
    check_slot(3, seg_tab[5], "wrap_d3");

    n = 0;
    while (AN !== 4'b1011 && n < 24) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 24) begin
      errors++;
      $error("FAIL ar_wait: AN 1011 never seen");
    end
    `CHK("ar_wait_an", AN, 4'b1011)
    #2;
    rst_n = 1'b0;
    #1;
    `CHK("ar_cnt", rx_count, 4'd0)
    `CHK("ar_an", AN, 4'b1110)
    `CHK("ar_seg", seven_seg, BLANK)
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    `CHK("ar_rel_an", AN, 4'b1110)
    `CHK("ar_rel_seg", seven_seg, BLANK)
    `CHK("ar_rel_cnt", rx_count, 4'd0)
    for (int i = 0; i < 4; i++)
      check_slot(i, BLANK, $sformatf("ar_d%0d", i));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_history_display.md
Name: rx_history_display

Overview:
- Downstream consumer of slave_control's received 3-bit data, on the slave FPGA board.
- Captures each newly delivered value into a 4-deep history: newest value on the rightmost digit, older values shifted left.
- Drives the 4-digit seven-segment display, time-multiplexed, showing the last four received values.
- Replaces the fixed single-digit display (AN tied to 4'b1110) on the slave board.

Parameters:
- REFRESH_BITS, 17, width of the free-running refresh counter; each digit is active for 2^(REFRESH_BITS-2) cycles.

Ports:
- clk  input  1  system clock (100 MHz on board)
- rst_n  input  1  asynchronous active-low reset
- data_valid  input  1  level from the link; data_in is captured on its 0->1 edge
- data_in  input  3  received value 0..7
- clear  input  1  synchronous clear pulse (already one-pulsed by the caller); empties the history
- seven_seg  output  7  active-low segments {g,f,e,d,c,b,a}
- AN  output  4  active-low digit enables; AN[0] is the rightmost digit
- rx_count  output  4  number of values captured since reset/clear; wraps modulo 16

Behaviour:
- Reset (rst_n=0, asynchronous):
  - history entries = 0, occupied flags = 0, rx_count = 0.
  - Refresh counter = 0; valid-edge register = 0.
  - AN = 4'b1110 and seven_seg = 7'b1111111 (blank) on the first cycle after release.
- Edge detect: register data_valid once (dv_q). capture = data_valid & ~dv_q.
  - A level held high produces exactly one capture.
- On capture (registered, 1-cycle latency; visible on the display from the next cycle):
  - entry[3] <= entry[2], entry[2] <= entry[1], entry[1] <= entry[0], entry[0] <= data_in.
  - Occupied flags shift the same way; occ[0] <= 1.
  - rx_count <= rx_count + 1; 15 wraps to 0.
  - The oldest entry is discarded once all four digits are occupied.
- Clear: on clear=1, all occupied flags = 0, entries = 0, rx_count = 0.
  - Clear has priority over a simultaneous capture; that capture is dropped, not stored.
  - The refresh counter is not affected by clear.
- Refresh:
  - REFRESH_BITS-bit counter increments every cycle and wraps freely.
  - sel = counter[REFRESH_BITS-1:REFRESH_BITS-2].
  - sel 0..3 drives AN = 1110, 1101, 1011, 0111 respectively; exactly one AN bit is low at all times after reset.
- Segment output:
  - seven_seg and AN are registered, so they change together on the same edge. The combinational path is sel -> selected entry -> pattern.
  - An unoccupied entry shows blank, 7'b1111111.
  - An occupied entry value v maps to:
    - 0 = 1000000
    - 1 = 1111001
    - 2 = 0100100
    - 3 = 0110000
    - 4 = 0011001
    - 5 = 0010010
    - 6 = 0000010
    - 7 = 1111000
- data_in is sampled only on the capture cycle; changes at any other time are ignored.
- Reset asserted mid-refresh or mid-capture returns to the reset state immediately; no partial shift survives.

Decomposition:
- Shared package holds:
  - the digit-to-segment constants (SEG_0..SEG_7, SEG_BLANK);
  - the AN one-cold patterns;
  - HIST_DEPTH = 4.
- One natural sub-module: seg_decode_3b, combinational 3-bit value plus occupied flag to 7-bit active-low pattern. It is instantiated once, after the digit mux.
- Edge detect, history shift register, counter and output registers stay in rx_history_display.

Test Plan (REFRESH_BITS=4, so each digit is active for 4 cycles; full scan = 16 cycles):
- Reset, then 16 idle cycles -> AN cycles 1110, 1101, 1011, 0111, four cycles each; seven_seg = 1111111 throughout; rx_count = 0.
- Present data_in = 3 and hold data_valid high for 10 cycles -> exactly one capture: rx_count = 1; AN = 1110 slot shows 0110000; other slots blank.
- Capture 1, 2, 5, 7, 4 in sequence, with data_valid low between captures -> rx_count = 5:
  - AN0 = 4 (0011001), AN1 = 7 (1111000), AN2 = 5 (0010010), AN3 = 2 (0100100);
  - value 1 is discarded.
- Assert clear in the same cycle as a data_valid rising edge with data_in = 6 -> all digits blank; rx_count = 0; 6 is not stored.
  - A following capture of 0 shows 1000000 on AN0 only.
- Seventeen captures -> rx_count wraps to 1; the display shows the last four values.
- Assert rst_n low asynchronously between clock edges, mid-scan with AN = 1011 -> all history and the counter clear without waiting for a clock edge.
  - After release: AN = 1110 and blank segments.
